// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the unified-memory SRAM arbiter.
package sram_arb_pkg;

   // Records which requester owns the read response that returns next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } rsp_own_e;

   localparam int unsigned SRAM_ARB_MAX_DSTREAK = 4;

   // Width needed to count 0..max_streak inclusive.
   function automatic int unsigned streak_width(input int unsigned max_streak);
      return $clog2(max_streak + 1);
   endfunction

endpackage

// File: rtl/arb_streak_cnt.sv
// Saturating count of consecutive data grants taken while a fetch waits.
// at_limit tells the arbiter that fetch must win the next contended cycle.
module arb_streak_cnt
   import sram_arb_pkg::*;
#(
   parameter int unsigned MAX_DSTREAK = SRAM_ARB_MAX_DSTREAK,
   parameter int unsigned CNT_W       = streak_width(MAX_DSTREAK)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] streak,
   output logic             at_limit
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_DSTREAK);

   assign at_limit = (streak == LIMIT);

   // Clear wins over increment; the count holds once it reaches the limit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         streak <= '0;
      end else if (clr) begin
         streak <= '0;
      end else if (inc && !at_limit) begin
         streak <= streak + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data
// access. Data has priority; fetch is forced through after MAX_DSTREAK
// consecutive data grants taken while it was waiting. Read data returns one
// cycle after grant and is steered back by the response-owner register.
//
// rsp_own   | meaning
// ----------+---------------------------------------------------
// OWN_NONE  | no read issued last cycle (idle, write, or reset)
// OWN_INST  | last cycle granted a fetch; mem_rdata belongs to inst
// OWN_DATA  | last cycle granted a data read; mem_rdata belongs to data
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_DSTREAK = SRAM_ARB_MAX_DSTREAK
) (
   input  logic                clk,
   input  logic                resetn,

   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_gnt,
   output logic                inst_rvalid,
   output logic [DATA_W-1:0]   inst_rdata,

   input  logic                data_req,
   input  logic [DATA_W/8-1:0] data_wen,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_gnt,
   output logic                data_rvalid,
   output logic [DATA_W-1:0]   data_rdata,

   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned CNT_W = streak_width(MAX_DSTREAK);

   logic [CNT_W-1:0] streak;
   logic             at_limit;
   logic             data_is_read;
   rsp_own_e         rsp_own;
   rsp_own_e         rsp_own_d;

   assign data_is_read = (data_wen == '0);

   // Fetch only loses to data while the streak guard has not tripped.
   assign inst_gnt = inst_req & (~data_req | at_limit);
   assign data_gnt = data_req & ~(inst_req & at_limit);
   assign mem_en   = inst_gnt | data_gnt;

   // Count data grants only while fetch is actually being held off; a low
   // inst_req means nobody is starving, so the guard rearms from zero.
   arb_streak_cnt #(
      .MAX_DSTREAK (MAX_DSTREAK),
      .CNT_W       (CNT_W)
   ) u_streak (
      .clk      (clk),
      .resetn   (resetn),
      .inc      (data_gnt & inst_req),
      .clr      (inst_gnt | ~inst_req),
      .streak   (streak),
      .at_limit (at_limit)
   );

   // Steer the granted request onto the SRAM port; idle cycles drive zeros.
   always_comb begin
      mem_wen   = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (data_gnt) begin
         mem_wen   = data_wen;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end else if (inst_gnt) begin
         mem_addr  = inst_addr;
      end
   end

   // Decide who owns next cycle's mem_rdata; writes produce no response.
   always_comb begin
      rsp_own_d = OWN_NONE;
      if (inst_gnt) begin
         rsp_own_d = OWN_INST;
      end else if (data_gnt && data_is_read) begin
         rsp_own_d = OWN_DATA;
      end
   end

   // Response owner register; reset drops any response in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rsp_own <= OWN_NONE;
      end else begin
         rsp_own <= rsp_own_d;
      end
   end

   assign inst_rvalid = (rsp_own == OWN_INST);
   assign data_rvalid = (rsp_own == OWN_DATA);
   assign inst_rdata  = mem_rdata;
   assign data_rdata  = mem_rdata;

   streak_bound_a : assert property (
      @(posedge clk) disable iff (!resetn) streak <= CNT_W'(MAX_DSTREAK)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a response
// scoreboard: stimulus pushes expected read data, a monitor pops on rvalid.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_gnt;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   logic [31:0] q_inst[$];
   logic [31:0] q_data[$];
   logic [31:0] mem_arr [0:255];

   sram_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .MAX_DSTREAK (4)
   ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_gnt    (inst_gnt),
      .inst_rvalid (inst_rvalid),
      .inst_rdata  (inst_rdata),
      .data_req    (data_req),
      .data_wen    (data_wen),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt),
      .data_rvalid (data_rvalid),
      .data_rdata  (data_rdata),
      .mem_en      (mem_en),
      .mem_wen     (mem_wen),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   // SRAM model: each word initially holds its own byte address.
   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'(i * 4);
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         if (mem_en) begin
            if (mem_wen == 4'h0) begin
               mem_rdata <= mem_arr[mem_addr[9:2]];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (mem_wen[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every rvalid must match the oldest expected response of its side.
   always @(negedge clk) begin
      if (inst_rvalid) begin
         if (q_inst.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL inst_rvalid_unexpected: got rvalid=1 rdata=%h expected no response", inst_rdata);
         end else begin
            chk("inst_rdata", inst_rdata, q_inst.pop_front());
         end
      end
      if (data_rvalid) begin
         if (q_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data_rvalid_unexpected: got rvalid=1 rdata=%h expected no response", data_rdata);
         end else begin
            chk("data_rdata", data_rdata, q_data.pop_front());
         end
      end
   end

   // Drive one cycle of requests, check grants and SRAM port, queue responses.
   task automatic do_cycle(input logic ireq, input logic [31:0] iaddr,
                           input logic dreq, input logic [3:0] dwen,
                           input logic [31:0] daddr, input logic [31:0] dwdata,
                           input logic exp_ig, input logic exp_dg,
                           input logic [31:0] exp_rd, input logic expect_rsp);
      inst_req   = ireq;
      inst_addr  = iaddr;
      data_req   = dreq;
      data_wen   = dwen;
      data_addr  = daddr;
      data_wdata = dwdata;
      @(negedge clk);
      chk("inst_gnt", 32'(inst_gnt), 32'(exp_ig));
      chk("data_gnt", 32'(data_gnt), 32'(exp_dg));
      chk("mem_en", 32'(mem_en), 32'(exp_ig | exp_dg));
      if (exp_dg) begin
         chk("mem_addr_data", mem_addr, daddr);
         chk("mem_wen_data", 32'(mem_wen), 32'(dwen));
         if (dwen != 4'h0) chk("mem_wdata", mem_wdata, dwdata);
      end else if (exp_ig) begin
         chk("mem_addr_inst", mem_addr, iaddr);
         chk("mem_wen_inst", 32'(mem_wen), 32'h0);
      end else begin
         chk("mem_addr_idle", mem_addr, 32'h0);
         chk("mem_wen_idle", 32'(mem_wen), 32'h0);
         chk("mem_wdata_idle", mem_wdata, 32'h0);
      end
      if (expect_rsp) begin
         if (exp_ig) q_inst.push_back(exp_rd);
         else if (exp_dg && dwen == 4'h0) q_data.push_back(exp_rd);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      do_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   // Both sides requesting from streak 0: four data reads, then fetch.
   task automatic contend(input logic [31:0] dbase, input logic [31:0] ia);
      for (int k = 0; k < 4; k++)
         do_cycle(1'b1, ia, 1'b1, 4'h0, dbase + 32'(4*k), 32'h0,
                  1'b0, 1'b1, dbase + 32'(4*k), 1'b1);
      do_cycle(1'b1, ia, 1'b1, 4'h0, dbase + 32'h10, 32'h0, 1'b1, 1'b0, ia, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn     = 1'b0;
      inst_req   = 1'b0;
      inst_addr  = '0;
      data_req   = 1'b0;
      data_wen   = '0;
      data_addr  = '0;
      data_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_inst_rvalid", 32'(inst_rvalid), 32'h0);
      chk("reset_data_rvalid", 32'(data_rvalid), 32'h0);
      chk("reset_mem_en", 32'(mem_en), 32'h0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Fetch-only stream, back-to-back responses.
      for (int a = 0; a < 16; a += 4)
         do_cycle(1'b1, 32'(a), 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'(a), 1'b1);
      idle();

      // Full-word write then read back.
      do_cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0);
      do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
      idle();

      // Contention: D,D,D,D,I twice, then fetch drops out.
      contend(32'h20, 32'h10);
      contend(32'h30, 32'h14);
      do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1);
      idle();

      // Byte-lane write merges into an existing word.
      do_cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h200, 32'h11223344, 1'b0, 1'b1, 32'h0, 1'b0);
      do_cycle(1'b0, 32'h0, 1'b1, 4'b0010, 32'h200, 32'h0000AB00, 1'b0, 1'b1, 32'h0, 1'b0);
      do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b1, 32'h1122AB44, 1'b1);
      idle();

      // Fetch request withdrawn while data holds the port; guard must rearm.
      do_cycle(1'b1, 32'h50, 1'b1, 4'h0, 32'h60, 32'h0, 1'b0, 1'b1, 32'h60, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h64, 32'h0, 1'b0, 1'b1, 32'h64, 1'b1);
      contend(32'h70, 32'h80);
      idle();

      // Reset during the response cycle of a data read drops the response.
      do_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      data_req = 1'b0;
      resetn   = 1'b0;
      #1;
      chk("reset_drops_data_rvalid", 32'(data_rvalid), 32'h0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      do_cycle(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 1'b1);
      idle();
      chk("inst_q_drained", 32'(q_inst.size()), 32'h0);
      chk("data_q_drained", 32'(q_data.size()), 32'h0);
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
